seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
Parametrised shift-add sequential multiplier with its controller integrated in the same block, so the datapath and FSM are no longer separate modules. It computes a WIDTH x WIDTH product, either unsigned or two's-complement signed, selected per operation. It processes one multiplier bit per clock and uses a start/busy/done handshake. It serves as the general multiply engine wherever single-cycle multiply area cannot be afforded.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = honour signed_mode; 0 = signed logic removed, signed_mode ignored, all operations unsigned.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request a multiply; sampled only in IDLE.
signed_mode  input  1  1 = treat operands as two's complement; sampled with start.
multiplicand  input  WIDTH  operand A; sampled with start.
multiplier  input  WIDTH  operand B; sampled with start.
busy  output  1  high while an operation is in progress (RUN or FIX).
done  output  1  one-cycle pulse when product is updated.
product  output  2*WIDTH  registered result; holds its value until the next done.

Behaviour:
- Reset (rst_n low, any time including mid-operation): state = IDLE; busy = 0; done = 0; product = 0; internal accumulator, operand registers and counter cleared. Any operation in flight is abandoned. No done is issued for it.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start = 1, latch the operands. In signed mode (signed_mode & SIGNED_EN), store abs(multiplicand) and abs(multiplier) as WIDTH-bit unsigned magnitudes, and store neg = sign(A) XOR sign(B). Otherwise store the operands unchanged with neg = 0.
  - Clear the accumulator, clear the counter, go to RUN.
  - The most-negative operand (e.g. -128 at WIDTH=8) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. No overflow is possible.
- RUN, one iteration per cycle:
  - If the multiplier register LSB = 1, add the multiplicand into the upper WIDTH+1 bits of the (2*WIDTH+1)-bit accumulator, carry kept.
  - Then shift the accumulator and the multiplier register right by 1.
  - The counter increments each cycle. After exactly WIDTH iterations go to FIX.
- FIX:
  - product <= neg ? -(accumulator[2W-1:0]) : accumulator[2W-1:0], taken mod 2^(2W).
  - done <= 1 for exactly this edge's following cycle. Return to IDLE.
- Latency: a start sampled at edge N gives done high and product valid in the cycle after edge N+WIDTH+1. Total WIDTH+2 cycles from start to done.
- busy = 1 from the cycle after start is accepted until the cycle in which done is high; busy = 0 in that done cycle.
- start while busy = 1 is ignored, with no queuing. The operand inputs may change freely during RUN and FIX.
- Back-to-back: start high in the done cycle is accepted (the FSM is in IDLE). The next done follows WIDTH+2 cycles later. product keeps the old result until then.
- Zero operands still take the full WIDTH+2 cycles; there is no early termination. Latency is fixed.
- SIGNED_EN = 0: neg is forced to 0 and the abs logic is not instantiated.
- Signed result range: magnitude is at most 2^(2W-2), so the result always fits in 2*WIDTH bits. Example: (-128)*(-128) = 0x4000.

Test Plan:
WIDTH=8, unsigned: start with A=13, B=11 -> done exactly 10 cycles after the start edge, product=0x008F, busy high for 9 cycles before done.
WIDTH=8, unsigned: A=255, B=255 -> product=0xFE01; then signed_mode=1 with A=0xFD (-3), B=5 -> product=0xFFF1 (-15).
WIDTH=8, signed: A=0x80, B=0x80 -> product=0x4000; A=0x80, B=0x01 -> product=0xFF80; A=0, B=0x80 -> product=0x0000 with neg handling yielding 0.
start pulsed again 3 cycles into an operation with different operands -> ignored; exactly one done, carrying the first result. start held high in the done cycle -> second operation accepted, second done 10 cycles later, product unchanged in between.
rst_n driven low asynchronously mid-RUN (between edges) -> busy, done and product go to 0 immediately. No done after rst_n is released. A fresh start then gives a correct result.
WIDTH=16 and WIDTH=3 instances, SIGNED_EN=0: randomised 1000 operand pairs checked against the reference model. signed_mode toggling has no effect. Latency is always WIDTH+2.

Source files
------------

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add sequential multiplier with an integrated controller.
// It computes a WIDTH x WIDTH product (2*WIDTH bits), unsigned or two's-complement
// signed, and retires one multiplier bit per clock. Signed operands are converted
// to magnitudes on entry, and the sign is reapplied in the FIX state.
module seq_mult_param #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_in;
  logic             w_last_iter;
  logic [WIDTH:0]   w_add_hi;
  logic [AW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_prod_fix;

  // Operand conditioning. The most-negative value negates to 2^(WIDTH-1), which
  // still fits in WIDTH unsigned bits, so no overflow handling is needed.
  generate
    if (SIGNED_EN != 0) begin : g_signed
      logic w_a_negative;
      logic w_b_negative;
      assign w_a_negative = signed_mode & multiplicand[WIDTH-1];
      assign w_b_negative = signed_mode & multiplier[WIDTH-1];
      assign w_a_mag  = w_a_negative ? (~multiplicand + {{(WIDTH-1){1'b0}}, 1'b1}) : multiplicand;
      assign w_b_mag  = w_b_negative ? (~multiplier + {{(WIDTH-1){1'b0}}, 1'b1}) : multiplier;
      assign w_neg_in = w_a_negative ^ w_b_negative;
    end else begin : g_unsigned
      logic w_unused_signed_mode;
      assign w_unused_signed_mode = signed_mode;
      assign w_a_mag  = multiplicand;
      assign w_b_mag  = multiplier;
      assign w_neg_in = 1'b0;
    end
  endgenerate

  // The upper WIDTH+1 accumulator bits absorb the multiplicand, then everything shifts right.
  // The accumulator MSB is always 0 here because of the previous shift, so the sum fits in WIDTH+1 bits.
  assign w_add_hi    = r_mplier[0] ? (r_acc[AW-1:WIDTH] + {1'b0, r_mcand}) : r_acc[AW-1:WIDTH];
  assign w_acc_nxt   = {1'b0, w_add_hi, r_acc[WIDTH-1:1]};
  assign w_prod_fix  = r_neg ? (~r_acc[PW-1:0] + {{(PW-1){1'b0}}, 1'b1}) : r_acc[PW-1:0];
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, FIX for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last_iter) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs: latch operands, iterate, then publish the signed-corrected product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= {AW{1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_mplier  <= {WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= {PW{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_neg_in;
            r_acc    <= {AW{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          r_product <= w_prod_fix;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed and randomised self-checking bench for seq_mult_param. It covers a
// signed 8-bit instance, plus unsigned-only 16-bit and 3-bit instances.
module tb_seq_mult_param;

  logic clk;
  logic rst_n;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        start3, sm3, busy3, done3;
  logic [2:0]  a3, b3;
  logic [5:0]  p3;

  int n_total;
  int n_pass;

  seq_mult_param #(.WIDTH(8), .SIGNED_EN(1)) u_m8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_mult_param #(.WIDTH(16), .SIGNED_EN(0)) u_m16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .busy(busy16), .done(done16), .product(p16)
  );

  seq_mult_param #(.WIDTH(3), .SIGNED_EN(0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm3),
    .multiplicand(a3), .multiplier(b3), .busy(busy3), .done(done3), .product(p3)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation. With now=1 the start is driven in the current cycle,
  // which the back-to-back case uses while it is still in the done cycle.
  // The latency count includes the start cycle, so done lands at WIDTH+2.
  task automatic op8(input logic now, input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input logic [15:0] prev, input string tag);
    int k;
    int bc;
    logic hold;
    if (!now) @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0; bc = 0; hold = 1'b1;
    while (!done8 && k < 40) begin
      if (busy8) bc++;
      if (p8 !== prev) hold = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_latency"}, 64'(k + 1), 64'd10);
    check_eq({tag, "_busy_cycles"}, 64'(bc), 64'd9);
    check_eq({tag, "_busy_in_done"}, 64'(busy8), 64'd0);
    check_eq({tag, "_product"}, 64'(p8), 64'(exp));
    check_eq({tag, "_hold"}, 64'(hold), 64'd1);
  endtask

  initial begin
    int k;
    int dcnt;
    int first_k;
    logic [15:0] first_p;
    logic [15:0] ra16, rb16;
    logic [2:0]  ra3, rb3;

    n_total = 0; n_pass = 0;
    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start16 = 1'b0; sm16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    start3 = 1'b0; sm3 = 1'b0; a3 = 3'd0; b3 = 3'd0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_done", 64'(done8), 64'd0);
    check_eq("rst_product", 64'(p8), 64'd0);
    check_eq("rst_product16", 64'(p16), 64'd0);
    check_eq("rst_product3", 64'(p3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 8-bit vectors, each with a hand-computed product.
    op8(1'b0, 1'b0, 8'd13,  8'd11,  16'h008F, 16'h0000, "u_13x11");
    op8(1'b0, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 16'h008F, "u_255x255");
    op8(1'b0, 1'b1, 8'hFD,  8'h05,  16'hFFF1, 16'hFE01, "s_m3x5");
    op8(1'b0, 1'b1, 8'h80,  8'h80,  16'h4000, 16'hFFF1, "s_m128xm128");
    op8(1'b0, 1'b1, 8'h80,  8'h01,  16'hFF80, 16'h4000, "s_m128x1");
    op8(1'b0, 1'b1, 8'h00,  8'h80,  16'h0000, 16'hFF80, "s_0xm128");
    op8(1'b0, 1'b0, 8'h80,  8'h01,  16'h0080, 16'h0000, "u_128x1");
    op8(1'b0, 1'b1, 8'hFF,  8'hFF,  16'h0001, 16'h0080, "s_m1xm1");
    op8(1'b0, 1'b1, 8'h7F,  8'h81,  16'hC0FF, 16'h0001, "s_127xm127");
    op8(1'b0, 1'b0, 8'h7F,  8'h81,  16'h3FFF, 16'hC0FF, "u_127x129");

    // A second start three cycles into the operation must be ignored.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd13; b8 = 8'd11;
    @(posedge clk); #1;
    start8 = 1'b0;
    dcnt = 0; first_k = -1; first_p = 16'h0000;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) begin
        start8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        dcnt++;
        if (first_k < 0) begin
          first_k = i;
          first_p = p8;
        end
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    check_eq("ign_done_count", 64'(dcnt), 64'd1);
    check_eq("ign_latency", 64'(first_k + 1), 64'd10);
    check_eq("ign_product", 64'(first_p), 64'h008F);

    // Back-to-back: the second start is raised while done is high.
    op8(1'b0, 1'b0, 8'd7, 8'd9, 16'h003F, 16'h008F, "b2b_first");
    op8(1'b1, 1'b0, 8'd5, 8'd6, 16'h001E, 16'h003F, "b2b_second");
    @(posedge clk); #1;
    check_eq("b2b_done_pulse", 64'(done8), 64'd0);

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy8), 64'd0);
    check_eq("arst_done", 64'(done8), 64'd0);
    check_eq("arst_product", 64'(p8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcnt++;
    end
    check_eq("arst_no_done", 64'(dcnt), 64'd0);
    op8(1'b0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 16'h0000, "post_rst");

    // 16-bit unsigned-only instance: random operands with signed_mode toggling.
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      if (i == 0) begin
        ra16 = 16'hFFFF; rb16 = 16'hFFFF;
      end
      @(negedge clk);
      start16 = 1'b1; sm16 = 1'($urandom); a16 = ra16; b16 = rb16;
      @(posedge clk); #1;
      start16 = 1'b0; sm16 = ~sm16;
      k = 0;
      while (!done16 && k < 60) begin
        @(posedge clk); #1;
        k++;
      end
      check_eq("w16_latency", 64'(k + 1), 64'd18);
      check_eq("w16_product", 64'(p16), 64'(32'(ra16) * 32'(rb16)));
    end

    // 3-bit unsigned-only instance: random operands with signed_mode toggling.
    for (int i = 0; i < 1000; i++) begin
      ra3 = 3'($urandom);
      rb3 = 3'($urandom);
      if (i == 0) begin
        ra3 = 3'd7; rb3 = 3'd7;
      end
      @(negedge clk);
      start3 = 1'b1; sm3 = 1'($urandom); a3 = ra3; b3 = rb3;
      @(posedge clk); #1;
      start3 = 1'b0; sm3 = ~sm3;
      k = 0;
      while (!done3 && k < 30) begin
        @(posedge clk); #1;
        k++;
      end
      check_eq("w3_latency", 64'(k + 1), 64'd5);
      check_eq("w3_product", 64'(p3), 64'(6'(ra3) * 6'(rb3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
